// File: rtl/demux_1to2_stream.sv
// Registered 1:2 stream demultiplexer: one valid/ready source is steered per beat
// into one of two single-entry output holding registers, with per-output beat counters.
module demux_1to2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             sel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout_0,
    output logic             dout_0_valid,
    input  logic             dout_0_ready,
    output logic [WIDTH-1:0] dout_1,
    output logic             dout_1_valid,
    input  logic             dout_1_ready,
    output logic [CNT_W-1:0] cnt_0,
    output logic [CNT_W-1:0] cnt_1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      st0_q, st0_d, st1_q, st1_d;
    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic accept, accept0, accept1, drain0, drain1;

    // Only the addressed slot gates the input, so a stalled consumer never blocks the other.
    assign din_ready = rst_n & (sel ? ((st1_q == EMPTY) | dout_1_ready)
                                    : ((st0_q == EMPTY) | dout_0_ready));
    assign accept    = din_valid & din_ready;
    assign accept0   = accept & ~sel;
    assign accept1   = accept &  sel;
    assign drain0    = (st0_q == FULL) & dout_0_ready;
    assign drain1    = (st1_q == FULL) & dout_1_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        st0_d   = st0_q;
        st1_d   = st1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        case (st0_q)
            EMPTY: if (accept0) st0_d = FULL;
            FULL:  if (drain0 && !accept0) st0_d = EMPTY;
            default: st0_d = EMPTY;
        endcase

        case (st1_q)
            EMPTY: if (accept1) st1_d = FULL;
            FULL:  if (drain1 && !accept1) st1_d = EMPTY;
            default: st1_d = EMPTY;
        endcase

        // A full slot only accepts when it is also draining, so loading never overwrites a held beat.
        if (accept0) begin
            data0_d = din;
            cnt0_d  = cnt0_q + CNT_W'(1);
        end
        if (accept1) begin
            data1_d = din;
            cnt1_d  = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is sampled at the edge and overrides any transfer.
        if (!rst_n) begin
            st0_q   <= EMPTY;
            st1_q   <= EMPTY;
            data0_q <= '0;
            data1_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            st0_q   <= st0_d;
            st1_q   <= st1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign dout_0       = data0_q;
    assign dout_1       = data1_q;
    assign dout_0_valid = (st0_q == FULL);
    assign dout_1_valid = (st1_q == FULL);
    assign cnt_0        = cnt0_q;
    assign cnt_1        = cnt1_q;

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Scoreboard bench for demux_1to2_stream: the driver pushes each accepted beat into a
// per-output queue, and a negedge monitor pops and compares on every output drain.
module tb_demux_1to2_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             sel;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] dout_0, dout_1;
    logic             dout_0_valid, dout_1_valid;
    logic             dout_0_ready, dout_1_ready;
    logic [CNT_W-1:0] cnt_0, cnt_1;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls   = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] exp0[$];
    logic [WIDTH-1:0] exp1[$];

    bit               hold0 = 1'b0, hold1 = 1'b0;
    logic [WIDTH-1:0] last0, last1;

    demux_1to2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .sel          (sel),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .dout_0       (dout_0),
        .dout_0_valid (dout_0_valid),
        .dout_0_ready (dout_0_ready),
        .dout_1       (dout_1),
        .dout_1_valid (dout_1_valid),
        .dout_1_ready (dout_1_ready),
        .cnt_0        (cnt_0),
        .cnt_1        (cnt_1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat, wait (bounded) for the handshake, and record the expected output.
    task automatic send(input logic s, input logic [WIDTH-1:0] d);
        int waited = 0;
        din       = d;
        sel       = s;
        din_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (din_ready === 1'b1) break;
            waited++;
            stalls++;
            if (waited > 50) begin
                check("send_timeout", 32'(waited), 0);
                break;
            end
        end
        if (waited <= 50) begin
            if (s) exp1.push_back(d);
            else   exp0.push_back(d);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        repeat (2) @(posedge clk);
        #1;
        check("drained_0", exp0.size(), 0);
        check("drained_1", exp1.size(), 0);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stalls = 0;
    endtask

    // Monitor: every drain pops the scoreboard; a stalled output must hold its data.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                hold0 = 1'b0;
                hold1 = 1'b0;
            end else begin
                if (hold0) begin
                    check("hold_valid_0", dout_0_valid, 1'b1);
                    check("hold_data_0", dout_0, last0);
                end
                if (hold1) begin
                    check("hold_valid_1", dout_1_valid, 1'b1);
                    check("hold_data_1", dout_1, last1);
                end
                if (dout_0_valid && dout_0_ready) begin
                    if (exp0.size() == 0) check("unexpected_beat_0", dout_0, 32'hDEAD);
                    else                  check("mon_dout_0", dout_0, exp0.pop_front());
                end
                if (dout_1_valid && dout_1_ready) begin
                    if (exp1.size() == 0) check("unexpected_beat_1", dout_1, 32'hDEAD);
                    else                  check("mon_dout_1", dout_1, exp1.pop_front());
                end
                hold0 = dout_0_valid && !dout_0_ready;
                hold1 = dout_1_valid && !dout_1_ready;
                last0 = dout_0;
                last1 = dout_1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int start;

        // 1: reset held with a pending beat
        rst_n        = 1'b0;
        din          = 8'hFF;
        sel          = 1'b0;
        din_valid    = 1'b1;
        dout_0_ready = 1'b1;
        dout_1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_din_ready", din_ready, 1'b0);
        check("rst_valid_0", dout_0_valid, 1'b0);
        check("rst_valid_1", dout_1_valid, 1'b0);
        check("rst_dout_0", dout_0, 8'h00);
        check("rst_dout_1", dout_1, 8'h00);
        check("rst_cnt_0", cnt_0, 4'd0);
        check("rst_cnt_1", cnt_1, 4'd0);
        rst_n     = 1'b1;
        din_valid = 1'b0;

        // 2: alternating select, one-cycle latency
        send(1'b0, 8'hA1);
        check("t2_lat_0a", {dout_0_valid, dout_0}, {1'b1, 8'hA1});
        send(1'b1, 8'hB2);
        check("t2_lat_1a", {dout_1_valid, dout_1}, {1'b1, 8'hB2});
        send(1'b0, 8'hC3);
        check("t2_lat_0b", {dout_0_valid, dout_0}, {1'b1, 8'hC3});
        send(1'b1, 8'hD4);
        check("t2_lat_1b", {dout_1_valid, dout_1}, {1'b1, 8'hD4});
        check("t2_cnt_0", cnt_0, 4'd2);
        check("t2_cnt_1", cnt_1, 4'd2);
        do_reset();

        // 3: blocked output 0 does not stall output 1
        dout_0_ready = 1'b0;
        send(1'b0, 8'h11);
        din       = 8'h22;
        sel       = 1'b0;
        din_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_ready_blocked", din_ready, 1'b0);
            check("t3_hold_0", {dout_0_valid, dout_0}, {1'b1, 8'h11});
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        send(1'b1, 8'h33);
        check("t3_other_out", {dout_1_valid, dout_1}, {1'b1, 8'h33});
        check("t3_still_hold_0", dout_0, 8'h11);
        fork
            send(1'b0, 8'h22);
            begin
                repeat (2) @(posedge clk);
                #1;
                dout_0_ready = 1'b1;
            end
        join
        check("t3_reload_0", {dout_0_valid, dout_0}, {1'b1, 8'h22});
        check("t3_cnt_0", cnt_0, 4'd2);
        check("t3_cnt_1", cnt_1, 4'd1);
        do_reset();

        // 4: ten back-to-back beats to output 1
        start = cyc;
        for (int i = 0; i < 10; i++) send(1'b1, 8'h40 + 8'(i));
        check("t4_stalls", stalls, 0);
        check("t4_cycles", cyc - start, 10);
        check("t4_cnt_1", cnt_1, 4'd10);
        check("t4_cnt_0", cnt_0, 4'd0);
        do_reset();

        // 5: counter wrap at CNT_W = 4
        for (int i = 0; i < 17; i++) send(1'b0, 8'h80 + 8'(i));
        check("t5_cnt_0_wrap", cnt_0, 4'd1);
        check("t5_cnt_1", cnt_1, 4'd0);
        do_reset();

        // 6: reset with both outputs full discards in-flight beats
        dout_0_ready = 1'b0;
        dout_1_ready = 1'b0;
        send(1'b0, 8'h55);
        send(1'b1, 8'h66);
        check("t6_full", {dout_0_valid, dout_1_valid}, 2'b11);
        check("t6_cnts", {cnt_0, cnt_1}, {4'd1, 4'd1});
        exp0.delete();
        exp1.delete();
        rst_n     = 1'b0;
        din       = 8'h77;
        sel       = 1'b0;
        din_valid = 1'b1;
        @(negedge clk);
        check("t6_ready_in_rst", din_ready, 1'b0);
        @(posedge clk);
        #1;
        check("t6_valids", {dout_0_valid, dout_1_valid}, 2'b00);
        check("t6_cnt_0", cnt_0, 4'd0);
        check("t6_cnt_1", cnt_1, 4'd0);
        check("t6_dout", {dout_0, dout_1}, 16'h0000);
        rst_n        = 1'b1;
        din_valid    = 1'b0;
        dout_0_ready = 1'b1;
        dout_1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_ghost", {dout_0_valid, dout_1_valid}, 2'b00);
        check("end_drained_0", exp0.size(), 0);
        check("end_drained_1", exp1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
